// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive-only slave with input synchronisers, per-frame mode latch and valid/ready output
module spi_slave_rx #(
    parameter int DLY         = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_W       = $clog2(DATA_WIDTH + 1),
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [LEN_W-1:0]      length,
    input  logic                  spi_sclk,
    input  logic                  spi_csn,
    input  logic                  spi_sdi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_vld,
    input  logic                  rx_rdy,
    output logic                  rx_irq,
    output logic                  rx_abort,
    output logic                  rx_overrun,
    input  logic                  ovr_clr
);

    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       SHIFT   = 2'd1;
    localparam logic [1:0]       HOLD    = 2'd2;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic [1:0]             state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d, len_q, len_d;
    logic                   samp_rise_q, samp_rise_d, lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0]  sh_q, sh_d, data_q, data_d;
    logic                   vld_q, vld_d, irq_q, irq_d, abort_q, abort_d, ovr_q, ovr_d;
    logic                   sclk_s, csn_s, sdi_s;
    logic                   sclk_rise, sclk_fall, csn_fall, csn_rise, sample, done, ovr_set;
    logic [LEN_W-1:0]       len_eff;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign sample    = samp_rise_q ? sclk_rise : sclk_fall;
    assign len_eff   = (length == '0 || length > LEN_MAX) ? LEN_MAX : length;

    // Frame FSM: start on csn fall, assemble bits on sample edges, drop partial word on early csn rise
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        len_d       = len_q;
        samp_rise_d = samp_rise_q;
        lsb_d       = lsb_q;
        done        = 1'b0;
        abort_d     = 1'b0;
        if (state_q == IDLE) begin
            if (csn_fall) begin
                state_d     = SHIFT;
                cnt_d       = '0;
                sh_d        = '0;
                len_d       = len_eff;
                samp_rise_d = cpol == cpha;
                lsb_d       = lsb_first;
            end
        end else if (csn_rise) begin
            state_d = IDLE;
            abort_d = state_q == SHIFT;
        end else if (state_q == SHIFT && sample) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = lsb_q ? (sh_q | (DATA_WIDTH'(sdi_s) << cnt_q)) : {sh_q[DATA_WIDTH-2:0], sdi_s};
            if (cnt_d == len_q) begin
                state_d = HOLD;
                done    = 1'b1;
            end
        end
    end

    // Output buffer: a completed word loads only if the slot is empty or being drained this cycle
    always_comb begin
        vld_d   = (vld_q && rx_rdy) ? 1'b0 : vld_q;
        data_d  = data_q;
        ovr_set = 1'b0;
        irq_d   = done;
        if (done) begin
            if (!vld_q || rx_rdy) begin
                data_d = sh_d;
                vld_d  = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        ovr_d = ovr_set | (ovr_q & ~ovr_clr);
    end

    // Synchronisers and edge-detect history, reset to the idle bus levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
        end
    end

    // Frame state, latched configuration and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            samp_rise_q <= 1'b0;
            lsb_q       <= 1'b0;
            sh_q        <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            irq_q       <= 1'b0;
            abort_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            samp_rise_q <= samp_rise_d;
            lsb_q       <= lsb_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            irq_q       <= irq_d;
            abort_q     <= abort_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_vld     = vld_q;
    assign rx_irq     = irq_q;
    assign rx_abort   = abort_q;
    assign rx_overrun = ovr_q;

endmodule
